// File: rtl/nco_sweep_pkg.sv
// Shared types and default sizing for the NCO sweep controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nco_sweep_pkg;

  localparam int DEF_PHASE_WIDTH  = 64;
  localparam int DEF_CE_DIV_WIDTH = 16;
  localparam int DEF_DWELL_WIDTH  = 24;

  // Sweep sequencer states; LAST means the stop value is being dwelt on.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    LAST  = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/sample_ce_divider.sv
// Free-running clock-enable divider: one-cycle strobe every div_i+1 cycles.
// Latency: strobe appears div_i+1 cycles after a synchronous clear.
// Backpressure: none; the strobe is unconditional and cannot be stalled.
module sample_ce_divider
  import nco_sweep_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_CE_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 ce_o
);

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic                 ce_q;
  logic                 ce_d;

  // Next count wraps at the divisor; the strobe is registered so it is high
  // exactly in the cycle the counter sits on its terminal value.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q >= div_i) begin
      cnt_d = '0;
    end
    ce_d = (cnt_d == div_i);
  end

  // Counter and strobe registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/nco_sweep_controller.sv
// Stepped linear frequency sweep: drives sample_clk_ce and phase_increment.
// Latency: increment valid 1 cycle after start; each step 1 cycle after the dwell's last strobe.
// Backpressure: none; start is dropped (not queued) while busy, abort wins over start.
module nco_sweep_controller
  import nco_sweep_pkg::*;
#(
  parameter int PHASE_WIDTH  = DEF_PHASE_WIDTH,
  parameter int CE_DIV_WIDTH = DEF_CE_DIV_WIDTH,
  parameter int DWELL_WIDTH  = DEF_DWELL_WIDTH
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    repeat_mode,
  input  logic [CE_DIV_WIDTH-1:0] ce_divider,
  input  logic [PHASE_WIDTH-1:0]  start_increment,
  input  logic [PHASE_WIDTH-1:0]  stop_increment,
  input  logic [PHASE_WIDTH-1:0]  step_increment,
  input  logic [DWELL_WIDTH-1:0]  dwell_samples,
  output logic                    sample_clk_ce,
  output logic [PHASE_WIDTH-1:0]  phase_increment,
  output logic                    busy,
  output logic                    done,
  output logic                    sweep_wrap
);

  // Two guard bits: a signed value plus a full-width unsigned step cannot
  // wrap, so the clamp comparison against stop is always exact.
  localparam int EXT_W = PHASE_WIDTH + 2;
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

  sweep_state_t            state_q;
  logic [PHASE_WIDTH-1:0]  phase_q;
  logic [PHASE_WIDTH-1:0]  start_l_q;
  logic [PHASE_WIDTH-1:0]  stop_l_q;
  logic [PHASE_WIDTH-1:0]  step_l_q;
  logic [CE_DIV_WIDTH-1:0] div_l_q;
  logic [DWELL_WIDTH-1:0]  dwell_l_q;
  logic [DWELL_WIDTH-1:0]  dwell_cnt_q;
  logic                    repeat_l_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    wrap_q;

  logic                    start_acc;
  logic [CE_DIV_WIDTH-1:0] div_sel;
  logic                    ce;
  logic                    dir_up;
  logic                    dwell_end;
  logic                    degen_l;
  logic                    degen_in;
  logic [DWELL_WIDTH-1:0]  dwell_in;
  logic signed [EXT_W-1:0] cur_x;
  logic signed [EXT_W-1:0] step_x;
  logic signed [EXT_W-1:0] stop_x;
  logic signed [EXT_W-1:0] sum_x;
  logic [PHASE_WIDTH-1:0]  next_phase_d;

  // The divider sees the incoming divisor in the accept cycle so the first
  // strobe after start already uses the new rate.
  assign start_acc = (state_q == IDLE) && start && !abort;
  assign div_sel   = start_acc ? ce_divider : div_l_q;

  sample_ce_divider #(
    .DIV_WIDTH(CE_DIV_WIDTH)
  ) u_ce_div (
    .clk   (clk),
    .arst  (arst),
    .clr_i (start_acc),
    .div_i (div_sel),
    .ce_o  (ce)
  );

  // Next increment: step toward stop, clamped to stop once reached or passed.
  always_comb begin
    dir_up       = ($signed(stop_l_q) >= $signed(start_l_q));
    cur_x        = {{2{phase_q[PHASE_WIDTH-1]}}, phase_q};
    step_x       = {2'b00, step_l_q};
    stop_x       = {{2{stop_l_q[PHASE_WIDTH-1]}}, stop_l_q};
    sum_x        = dir_up ? (cur_x + step_x) : (cur_x - step_x);
    next_phase_d = sum_x[PHASE_WIDTH-1:0];
    if (dir_up ? (sum_x >= stop_x) : (sum_x <= stop_x)) begin
      next_phase_d = stop_l_q;
    end
  end

  // Dwell completes on the strobe that brings the per-step count to dwell_l.
  assign dwell_end = ce && (dwell_cnt_q == (dwell_l_q - DWELL_ONE));
  assign degen_l   = (start_l_q == stop_l_q) || (step_l_q == '0);
  assign degen_in  = (start_increment == stop_increment) || (step_increment == '0);
  assign dwell_in  = (dwell_samples == '0) ? DWELL_ONE : dwell_samples;

  // Sweep sequencer with registered outputs and latched configuration.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      start_l_q   <= '0;
      stop_l_q    <= '0;
      step_l_q    <= '0;
      div_l_q     <= '0;
      dwell_l_q   <= '0;
      dwell_cnt_q <= '0;
      repeat_l_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            start_l_q   <= start_increment;
            stop_l_q    <= stop_increment;
            step_l_q    <= step_increment;
            div_l_q     <= ce_divider;
            dwell_l_q   <= dwell_in;
            repeat_l_q  <= repeat_mode;
            phase_q     <= start_increment;
            dwell_cnt_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= degen_in ? LAST : SWEEP;
          end
        end
        SWEEP: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (dwell_end) begin
            phase_q     <= next_phase_d;
            dwell_cnt_q <= '0;
            if (next_phase_d == stop_l_q) begin
              state_q <= LAST;
            end
          end else if (ce) begin
            dwell_cnt_q <= dwell_cnt_q + DWELL_ONE;
          end
        end
        LAST: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (dwell_end) begin
            dwell_cnt_q <= '0;
            if (repeat_l_q) begin
              phase_q <= start_l_q;
              wrap_q  <= 1'b1;
              state_q <= degen_l ? LAST : SWEEP;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (ce) begin
            dwell_cnt_q <= dwell_cnt_q + DWELL_ONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sample_clk_ce   = ce;
  assign phase_increment = phase_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign sweep_wrap      = wrap_q;

endmodule

// File: tb/tb_nco_sweep_controller.sv
// Directed bench for the NCO sweep controller with hand-computed expectations.
module tb_nco_sweep_controller;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        repeat_mode = 1'b0;
  logic [15:0] ce_divider = '0;
  logic [63:0] start_increment = '0;
  logic [63:0] stop_increment = '0;
  logic [63:0] step_increment = '0;
  logic [23:0] dwell_samples = '0;
  logic        sample_clk_ce;
  logic [63:0] phase_increment;
  logic        busy;
  logic        done;
  logic        sweep_wrap;

  int vectors = 0;
  int errors  = 0;

  nco_sweep_controller dut (
    .clk             (clk),
    .arst            (arst),
    .start           (start),
    .abort           (abort),
    .repeat_mode     (repeat_mode),
    .ce_divider      (ce_divider),
    .start_increment (start_increment),
    .stop_increment  (stop_increment),
    .step_increment  (step_increment),
    .dwell_samples   (dwell_samples),
    .sample_clk_ce   (sample_clk_ce),
    .phase_increment (phase_increment),
    .busy            (busy),
    .done            (done),
    .sweep_wrap      (sweep_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then scramble the config inputs so any
  // use of unlatched configuration shows up in later checks.
  task automatic do_start(input logic [15:0] div, input logic [63:0] s, input logic [63:0] e,
                          input logic [63:0] st, input logic [23:0] dw, input logic rpt);
    ce_divider      = div;
    start_increment = s;
    stop_increment  = e;
    step_increment  = st;
    dwell_samples   = dw;
    repeat_mode     = rpt;
    start           = 1'b1;
    tick(1);
    start           = 1'b0;
    ce_divider      = 16'd7;
    start_increment = 64'h1234;
    stop_increment  = 64'h5678;
    step_increment  = 64'd1;
    dwell_samples   = 24'd5;
    repeat_mode     = ~rpt;
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_ce", sample_clk_ce, 1'b0);
    check("rst_phase", phase_increment, 64'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wrap", sweep_wrap, 1'b0);
    arst = 1'b0;
    tick(2);

    // Sweep 1: div=3, 100..130 step 10, dwell 2 (start at cycle t)
    do_start(16'd3, 64'd100, 64'd130, 64'd10, 24'd2, 1'b0);
    check("s1_t1_phase", phase_increment, 64'd100);
    check("s1_t1_busy", busy, 1'b1);
    check("s1_t1_ce", sample_clk_ce, 1'b0);
    tick(2);
    check("s1_t3_ce", sample_clk_ce, 1'b0);
    tick(1);
    check("s1_t4_ce", sample_clk_ce, 1'b1);
    check("s1_t4_phase", phase_increment, 64'd100);
    tick(4);
    check("s1_t8_ce", sample_clk_ce, 1'b1);
    check("s1_t8_phase", phase_increment, 64'd100);
    tick(1);
    check("s1_t9_phase", phase_increment, 64'd110);
    check("s1_t9_ce", sample_clk_ce, 1'b0);
    tick(8);
    check("s1_t17_phase", phase_increment, 64'd120);
    tick(8);
    check("s1_t25_phase", phase_increment, 64'd130);
    check("s1_t25_busy", busy, 1'b1);
    tick(7);
    check("s1_t32_ce", sample_clk_ce, 1'b1);
    check("s1_t32_done", done, 1'b0);
    check("s1_t32_busy", busy, 1'b1);
    tick(1);
    check("s1_t33_done", done, 1'b1);
    check("s1_t33_busy", busy, 1'b0);
    check("s1_t33_phase", phase_increment, 64'd130);

    // Sweep 2, started in the done cycle: div=0, 0..25 step 10, dwell 1
    do_start(16'd0, 64'd0, 64'd25, 64'd10, 24'd1, 1'b0);
    check("s2_u1_phase", phase_increment, 64'd0);
    check("s2_u1_busy", busy, 1'b1);
    check("s2_u1_ce", sample_clk_ce, 1'b1);
    check("s2_u1_done", done, 1'b0);
    tick(1);
    check("s2_u2_phase", phase_increment, 64'd10);
    tick(1);
    check("s2_u3_phase", phase_increment, 64'd20);
    tick(1);
    check("s2_u4_phase", phase_increment, 64'd25);
    check("s2_u4_busy", busy, 1'b1);
    tick(1);
    check("s2_u5_done", done, 1'b1);
    check("s2_u5_busy", busy, 1'b0);
    tick(1);
    check("s2_u6_done", done, 1'b0);
    check("s2_u6_phase", phase_increment, 64'd25);

    // Sweep 3: downward 50..-20 step 30, dwell 0 treated as 1
    do_start(16'd0, 64'd50, -64'sd20, 64'd30, 24'd0, 1'b0);
    check("s3_u1_phase", phase_increment, 64'd50);
    tick(1);
    check("s3_u2_phase", phase_increment, 64'd20);
    tick(1);
    check("s3_u3_phase", phase_increment, -64'sd10);
    tick(1);
    check("s3_u4_phase", phase_increment, -64'sd20);
    check("s3_u4_busy", busy, 1'b1);
    tick(1);
    check("s3_u5_done", done, 1'b1);
    tick(1);

    // Sweep 4: positive overflow must clamp, not wrap
    do_start(16'd0, 64'h7FFF_FFFF_FFFF_FFFB, 64'h7FFF_FFFF_FFFF_FFFF, 64'd10, 24'd1, 1'b0);
    check("s4_u1_phase", phase_increment, 64'h7FFF_FFFF_FFFF_FFFB);
    tick(1);
    check("s4_u2_phase", phase_increment, 64'h7FFF_FFFF_FFFF_FFFF);
    check("s4_u2_busy", busy, 1'b1);
    tick(1);
    check("s4_u3_done", done, 1'b1);
    check("s4_u3_phase", phase_increment, 64'h7FFF_FFFF_FFFF_FFFF);
    tick(1);

    // Sweep 5: repeat mode, div=1, 100..120 step 10, start while busy, then abort
    do_start(16'd1, 64'd100, 64'd120, 64'd10, 24'd1, 1'b1);
    check("s5_u1_phase", phase_increment, 64'd100);
    check("s5_u1_ce", sample_clk_ce, 1'b0);
    tick(1);
    check("s5_u2_ce", sample_clk_ce, 1'b1);
    tick(1);
    check("s5_u3_phase", phase_increment, 64'd110);
    start           = 1'b1;
    start_increment = 64'd999;
    ce_divider      = 16'd0;
    tick(1);
    start = 1'b0;
    check("s5_busy_start_phase", phase_increment, 64'd110);
    check("s5_u4_ce", sample_clk_ce, 1'b1);
    tick(1);
    check("s5_u5_phase", phase_increment, 64'd120);
    tick(1);
    check("s5_u6_wrap", sweep_wrap, 1'b0);
    tick(1);
    check("s5_u7_phase", phase_increment, 64'd100);
    check("s5_u7_wrap", sweep_wrap, 1'b1);
    check("s5_u7_done", done, 1'b0);
    check("s5_u7_busy", busy, 1'b1);
    tick(1);
    check("s5_u8_wrap", sweep_wrap, 1'b0);
    tick(1);
    check("s5_u9_phase", phase_increment, 64'd110);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("s5_abort_busy", busy, 1'b0);
    check("s5_abort_phase", phase_increment, 64'd110);
    check("s5_abort_done", done, 1'b0);
    tick(4);
    check("s5_idle_busy", busy, 1'b0);
    check("s5_idle_phase", phase_increment, 64'd110);
    check("s5_idle_wrap", sweep_wrap, 1'b0);

    // Simultaneous start and abort in IDLE: stay idle
    start_increment = 64'd77;
    stop_increment  = 64'd200;
    step_increment  = 64'd1;
    start           = 1'b1;
    abort           = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 1'b0);
    check("sa_phase", phase_increment, 64'd110);
    tick(1);
    check("sa_busy2", busy, 1'b0);

    // Degenerate sweep start == stop: straight to final dwell
    do_start(16'd0, 64'd42, 64'd42, 64'd10, 24'd1, 1'b0);
    check("dg_u1_phase", phase_increment, 64'd42);
    check("dg_u1_busy", busy, 1'b1);
    tick(1);
    check("dg_u2_done", done, 1'b1);
    check("dg_u2_busy", busy, 1'b0);
    tick(1);

    // Reset asserted mid-sweep
    do_start(16'd0, 64'd0, 64'd100, 64'd10, 24'd1, 1'b0);
    tick(2);
    check("rs_u3_phase", phase_increment, 64'd20);
    arst = 1'b1;
    tick(1);
    check("rs_phase", phase_increment, 64'd0);
    check("rs_busy", busy, 1'b0);
    check("rs_ce", sample_clk_ce, 1'b0);
    check("rs_done", done, 1'b0);
    check("rs_wrap", sweep_wrap, 1'b0);
    arst = 1'b0;
    tick(1);
    check("rs_rel_busy", busy, 1'b0);
    check("rs_rel_phase", phase_increment, 64'd0);
    check("rs_rel_ce", sample_clk_ce, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
